// File: rtl/sparc_exu_div_iter.sv
// sparc_exu_div_iter: iterative 64/32 restoring divider with overflow/zero detection, 35-cycle latency.
// Define EXU_SDIV_EN to enable signed (SDIV) support; otherwise every operation is UDIV.
module sparc_exu_div_iter (
    input  logic        clk,
    input  logic        arst_l,
    input  logic        div_start_e,
    input  logic [3:0]  div_thr_e,
    input  logic        div_signed_e,
    input  logic [31:0] yreg_mdq_y_e,
    input  logic [31:0] div_rs1_e,
    input  logic [31:0] div_rs2_e,
    input  logic        div_kill,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result,
    output logic [3:0]  div_thr_out,
    output logic        div_ovf,
    output logic        div_zero
);
    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, dvsr, abs_hi, abs_lo, abs_dvsr, fix_res, hi_next;
    logic [32:0] trial;
    logic        ovf_s, ge, fix_ovf;
`ifdef EXU_SDIV_EN
    logic        sgn, neg, dvd_neg, dvs_neg, pos_sat, neg_sat;
    always_comb begin
        dvd_neg = sgn & hi[31];
        dvs_neg = sgn & dvsr[31];
        {abs_hi, abs_lo} = dvd_neg ? -{hi, lo} : {hi, lo};
        abs_dvsr = dvs_neg ? -dvsr : dvsr;
        pos_sat = ovf_s | lo[31];
        neg_sat = ovf_s | (lo > 32'h8000_0000);
        fix_ovf = !sgn ? ovf_s : neg ? neg_sat : pos_sat;
        fix_res = !sgn ? (ovf_s ? 32'hffff_ffff : lo) :
                  neg  ? (neg_sat ? 32'h8000_0000 : -lo) :
                         (pos_sat ? 32'h7fff_ffff : lo);
    end
`else
    logic unused_signed;
    assign unused_signed = div_signed_e;
    always_comb begin
        abs_hi   = hi;
        abs_lo   = lo;
        abs_dvsr = dvsr;
        fix_ovf  = ovf_s;
        fix_res  = ovf_s ? 32'hffff_ffff : lo;
    end
`endif
    // hi holds the partial remainder; lo shifts dividend bits out and quotient bits in
    always_comb begin
        trial   = {hi, lo[31]};
        ge      = trial >= {1'b0, dvsr};
        hi_next = ge ? trial[31:0] - dvsr : trial[31:0];
    end
    assign div_busy = state != IDLE;
    assign div_done = state == DONE;
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            dvsr        <= '0;
            ovf_s       <= 1'b0;
            div_result  <= '0;
            div_thr_out <= '0;
            div_ovf     <= 1'b0;
            div_zero    <= 1'b0;
`ifdef EXU_SDIV_EN
            sgn         <= 1'b0;
            neg         <= 1'b0;
`endif
        end else if (div_kill) begin
            state    <= IDLE;
            cnt      <= '0;
            div_ovf  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (div_start_e) begin
                    state       <= SETUP;
                    hi          <= yreg_mdq_y_e;
                    lo          <= div_rs1_e;
                    dvsr        <= div_rs2_e;
                    div_thr_out <= div_thr_e;
                    div_result  <= '0;
                    div_ovf     <= 1'b0;
                    div_zero    <= 1'b0;
`ifdef EXU_SDIV_EN
                    sgn         <= div_signed_e;
`endif
                end
                SETUP: if (dvsr == '0) begin
                    state    <= DONE;
                    div_zero <= 1'b1;
                end else begin
                    state <= ITER;
                    hi    <= abs_hi;
                    lo    <= abs_lo;
                    dvsr  <= abs_dvsr;
                    ovf_s <= abs_hi >= abs_dvsr;
`ifdef EXU_SDIV_EN
                    neg   <= dvd_neg ^ dvs_neg;
`endif
                end
                ITER: begin
                    hi    <= hi_next;
                    lo    <= {lo[30:0], ge};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? FIX : ITER;
                end
                FIX: begin
                    state      <= DONE;
                    div_result <= fix_res;
                    div_ovf    <= fix_ovf;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
